fir_tdm_filter: RTL and testbench
=================================

FIR_TDM_FILTER -- requirements
Module: fir_tdm_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed sample width.
REQ-002 SHALL have parameter COEFF_WIDTH, default 8, signed coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 4, tap count (range 2..64).
REQ-004 SHALL have parameter OUT_WIDTH, default 12, signed output width.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before saturation.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports in_valid/in_ready  input/output  1/1  sample handshake.
REQ-009 SHALL have port x_in  input  DATA_WIDTH  signed sample.
REQ-010 SHALL have ports coef_we/coef_addr/coef_data  input  1/clog2(NUM_TAPS)/COEFF_WIDTH  coefficient write.
REQ-011 SHALL have ports out_valid/out_ready  output/input  1/1  result handshake.
REQ-012 SHALL have port y_out  output  OUT_WIDTH  signed filtered result.
REQ-013 SHALL have port sat  output  1  asserted with out_valid when y_out was clipped.

Function
REQ-014 SHALL implement y[n] = sum over k=0..NUM_TAPS-1 of coef[k]*x[n-k], using one time-multiplexed multiplier.
REQ-015 SHALL use FSM states IDLE, MAC, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-016 IDLE: on in_valid&&in_ready, shift delay line (tap[0]<=x_in, tap[k]<=tap[k-1]), clear accumulator, idx<=0, go to MAC.
REQ-017 MAC: each cycle acc += coef[idx]*tap[idx], idx++; after idx==NUM_TAPS-1, register the result into y_out/sat and go to OUT.
REQ-018 Latency: accept edge at cycle T gives out_valid high from cycle T+NUM_TAPS+1; max throughput is one sample per NUM_TAPS+2 cycles.
REQ-019 OUT: y_out and sat SHALL hold stable while out_ready=0; on out_valid&&out_ready, go to IDLE.
REQ-020 Accumulator width SHALL be DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS), signed full precision, and SHALL never overflow.
REQ-021 Rounding: if SHIFT>0, add 2^(SHIFT-1) to acc, then arithmetic shift right by SHIFT (round half up).
REQ-022 Saturation: clip the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; sat=1 iff clipped.
REQ-023 Coefficient writes SHALL take effect only in IDLE (coef[coef_addr]<=coef_data next edge); writes in MAC/OUT SHALL be ignored.
REQ-024 A coef_we and a sample accept in the same IDLE cycle: the write lands and the MAC SHALL use the new coefficient.
REQ-025 coef_addr >= NUM_TAPS SHALL be ignored.
REQ-026 in_valid while not in IDLE SHALL be ignored; the sample is not consumed and the source must hold it.

Reset
REQ-027 On reset: state=IDLE, delay line=0, acc=0, idx=0, y_out=0, sat=0, out_valid=0, in_ready=1 after release.
REQ-028 Reset coefficients: coef[0]=1, all others 0, giving pass-through when SHIFT=0.
REQ-029 Reset asserted mid-MAC or in OUT SHALL abort immediately with no out_valid pulse for the aborted sample.

Verification (DATA 8, COEFF 8, TAPS 4, OUT 12, SHIFT 0 unless stated)
REQ-030 Reset defaults, input 5, then -3 -> y_out 5, then -3; sat=0; out_valid at accept+5 cycles.
REQ-031 Impulse: coef {1,2,3,4}, input 1,0,0,0,0 -> outputs 1,2,3,4,0.
REQ-032 Saturation: all coef 127, four inputs 127 -> 4th y_out 2047, sat=1; all inputs -128 -> -2048, sat=1.
REQ-033 Backpressure: out_ready low 5 cycles in OUT -> y_out stable, in_ready=0, a held in_valid is not consumed; accepted after release.
REQ-034 Coefficient write to addr 1 during MAC is ignored (output unchanged); the same write in IDLE applies from the next sample.
REQ-035 SHIFT=2, coef {1,0,0,0}: input 6 -> 2; input -6 -> -1; reset pulse during MAC -> no out_valid, taps zeroed.

Source files
------------

// File: rtl/fir_tdm_filter_if.sv
// Sample, coefficient-write and result handshake bundle for fir_tdm_filter.
// master drives samples/coefficients and consumes results; slave is the filter.
interface fir_tdm_filter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int OUT_WIDTH   = 12
);
  localparam int ADDR_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  x_in;
  logic                          coef_we;
  logic [ADDR_W-1:0]             coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_data;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_WIDTH-1:0]   y_out;
  logic                          sat;

  modport master (
    output in_valid, x_in, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, y_out, sat
  );

  modport slave (
    input  in_valid, x_in, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, y_out, sat
  );
endinterface

// File: rtl/fir_tdm_filter.sv
// Time-multiplexed FIR: one multiplier walks the taps, then the rounded and
// saturated sum is held in OUT until the consumer takes it.
module fir_tdm_filter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int OUT_WIDTH   = 12,
  parameter int SHIFT       = 0
) (
  input  logic            clk,
  input  logic            reset,
  fir_tdm_filter_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
  localparam int SAT_W  = ACC_W + OUT_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]   TAP_CNT  = (ADDR_W + 1)'(NUM_TAPS);
  localparam logic signed [SAT_W-1:0] OUT_MAX =
    {{(SAT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [SAT_W-1:0] OUT_MIN =
    {{(SAT_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  // Half an output LSB; collapses to zero when SHIFT is 0.
  localparam logic [SAT_W-1:0] RND_BIAS = (SAT_W'(1) << SHIFT) >> 1;

  logic [1:0]                    state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  tap_q  [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [ADDR_W-1:0]             idx_q;
  logic signed [OUT_WIDTH-1:0]   y_q, y_d;
  logic                          sat_q, sat_d;

  logic signed [COEFF_WIDTH-1:0] coef_sel;
  logic signed [DATA_WIDTH-1:0]  tap_sel;
  logic signed [PROD_W-1:0]      prod;
  logic signed [SAT_W-1:0]       biased, shifted;
  logic                          accept, coef_wr;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign coef_wr = (state_q == IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} < TAP_CNT);

  always_comb begin
    coef_sel = coef_q[idx_q];
    tap_sel  = tap_q[idx_q];
    prod     = $signed({{DATA_WIDTH{coef_sel[COEFF_WIDTH-1]}}, coef_sel})
             * $signed({{COEFF_WIDTH{tap_sel[DATA_WIDTH-1]}}, tap_sel});
    acc_d    = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    // The final product is folded in here so y_out captures it on the last MAC edge.
    biased   = $signed({{(SAT_W - ACC_W){acc_d[ACC_W-1]}}, acc_d}) + $signed(RND_BIAS);
    shifted  = biased >>> SHIFT;
    if (shifted > OUT_MAX) begin
      y_d   = OUT_MAX[OUT_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (shifted < OUT_MIN) begin
      y_d   = OUT_MIN[OUT_WIDTH-1:0];
      sat_d = 1'b1;
    end else begin
      y_d   = shifted[OUT_WIDTH-1:0];
      sat_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (idx_q == LAST_IDX) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
      end
      coef_q[0] <= COEFF_WIDTH'(1);
    end else begin
      state_q <= state_d;
      if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
        tap_q[0] <= bus.x_in;
        for (int unsigned k = 1; k < NUM_TAPS; k++) tap_q[k] <= tap_q[k-1];
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == MAC) begin
        acc_q <= acc_d;
        idx_q <= idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          y_q   <= y_d;
          sat_q <= sat_d;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.y_out     = y_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_fir_tdm_filter.sv
// Directed bench: a plain sum-of-products reference checked every cycle on the
// SHIFT=0 instance, plus literal expectations on both SHIFT=0 and SHIFT=2 instances.
module tb_fir_tdm_filter;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NT = 4;
  localparam int OW = 12;
  localparam int S0 = 0;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst2 = 1'b1;
  logic sel  = 1'b0;
  logic iv   = 1'b0;
  logic we   = 1'b0;
  logic ordy = 1'b1;
  logic chk_en = 1'b0;
  logic signed [DW-1:0] xv = '0;
  logic [1:0]           wa = '0;
  logic signed [CW-1:0] wd = '0;

  always #5 clk = ~clk;

  fir_tdm_filter_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .OUT_WIDTH(OW)) b0 ();
  fir_tdm_filter_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .OUT_WIDTH(OW)) b2 ();

  fir_tdm_filter #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .OUT_WIDTH(OW), .SHIFT(0))
    dut0 (.clk(clk), .reset(rst0), .bus(b0));
  fir_tdm_filter #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .OUT_WIDTH(OW), .SHIFT(2))
    dut2 (.clk(clk), .reset(rst2), .bus(b2));

  assign b0.in_valid  = iv & ~sel;
  assign b0.x_in      = xv;
  assign b0.coef_we   = we & ~sel;
  assign b0.coef_addr = wa;
  assign b0.coef_data = wd;
  assign b0.out_ready = ordy;
  assign b2.in_valid  = iv & sel;
  assign b2.x_in      = xv;
  assign b2.coef_we   = we & sel;
  assign b2.coef_addr = wa;
  assign b2.coef_data = wd;
  assign b2.out_ready = ordy;

  logic signed [31:0] ov, ir, so, yo, ov0, ir0, so0, y0;
  assign ov  = {31'b0, sel ? b2.out_valid : b0.out_valid};
  assign ir  = {31'b0, sel ? b2.in_ready : b0.in_ready};
  assign so  = {31'b0, sel ? b2.sat : b0.sat};
  assign yo  = 32'(sel ? b2.y_out : b0.y_out);
  assign ov0 = {31'b0, b0.out_valid};
  assign ir0 = {31'b0, b0.in_ready};
  assign so0 = {31'b0, b0.sat};
  assign y0  = 32'(b0.y_out);

  int vectors = 0;
  int miscompares = 0;

  int imp_exp  [5] = '{1, 2, 3, 4, 0};
  int neg_exp  [4] = '{2047, -254, -2048, -2048};
  int neg_sat  [4] = '{1, 0, 1, 1};

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference for the SHIFT=0 instance: its own coefficient table, sample
  // history and busy/latency bookkeeping, fed only by the stimulus signals.
  int m_coef [NT];
  int m_hist [NT];
  bit m_busy;
  int m_cnt;
  int ey [$];
  int es [$];

  always @(posedge clk or posedge rst0) begin
    if (rst0) begin
      for (int k = 0; k < NT; k++) begin
        m_coef[k] = (k == 0) ? 1 : 0;
        m_hist[k] = 0;
      end
      m_busy = 1'b0;
      m_cnt  = 0;
      ey.delete();
      es.delete();
    end else if (!m_busy) begin
      if (b0.coef_we && int'(b0.coef_addr) < NT) m_coef[b0.coef_addr] = int'(b0.coef_data);
      if (b0.in_valid) begin
        int sum, div, r, q;
        for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = int'(b0.x_in);
        sum = 0;
        for (int k = 0; k < NT; k++) sum += m_coef[k] * m_hist[k];
        div = 1;
        for (int i = 0; i < S0; i++) div *= 2;
        r = sum + div / 2;
        q = r / div;
        if (r < 0 && (r % div) != 0) q--;
        if (q > 2 ** (OW - 1) - 1) begin ey.push_back(2 ** (OW - 1) - 1); es.push_back(1); end
        else if (q < -(2 ** (OW - 1))) begin ey.push_back(-(2 ** (OW - 1))); es.push_back(1); end
        else begin ey.push_back(q); es.push_back(0); end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (m_cnt >= NT) begin
      if (b0.out_ready) begin
        m_busy = 1'b0;
        if (ey.size() > 0) begin void'(ey.pop_front()); void'(es.pop_front()); end
      end
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst0) begin
      check("out_valid", ov0, int'(m_busy && m_cnt >= NT));
      check("in_ready", ir0, int'(!m_busy));
      if (m_busy && m_cnt >= NT) begin
        if (ey.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL model_queue: got out_valid with no accepted sample, expected an entry");
        end else begin
          check("y_out", y0, ey[0]);
          check("sat", so0, es[0]);
        end
      end
    end
  end

  task automatic push(input int x, input int w, input int a, input int d);
    int n;
    n  = 0;
    iv = 1'b1;
    xv = x[DW-1:0];
    we = w[0];
    wa = a[1:0];
    wd = d[CW-1:0];
    while (ir == 0 && n < 20) begin @(negedge clk); n++; end
    if (ir == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready %0d after %0d cycles, expected 1", ir, n);
    end
    @(negedge clk);
    iv = 1'b0;
    we = 1'b0;
  endtask

  task automatic send(input int x);
    push(x, 0, 0, 0);
  endtask

  task automatic wcoef(input int a, input int d);
    we = 1'b1;
    wa = a[1:0];
    wd = d[CW-1:0];
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic expect_out(input string name, input int y, input int s, output int lat);
    lat = 1;
    while (ov == 0 && lat < 20) begin @(negedge clk); lat++; end
    check({name, "_valid"}, ov, 1);
    check({name, "_y"}, yo, y);
    check({name, "_sat"}, so, s);
    if (ordy) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    check("rst_y", y0, 0);
    check("rst_sat", so0, 0);
    check("rst_out_valid", ov0, 0);
    check("rst_in_ready", ir0, 1);
    chk_en = 1'b1;

    send(5);  expect_out("pass5", 5, 0, lat);
    check("latency", lat, NT + 1);
    send(-3); expect_out("pass_m3", -3, 0, lat);

    for (int i = 0; i < NT; i++) begin send(0); expect_out("flush", 0, 0, lat); end
    for (int k = 0; k < NT; k++) wcoef(k, k + 1);
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 1 : 0);
      expect_out($sformatf("impulse%0d", i), imp_exp[i], 0, lat);
    end

    for (int k = 0; k < NT; k++) wcoef(k, 127);
    for (int i = 0; i < NT; i++) begin send(127); expect_out("sat_pos", 2047, 1, lat); end
    for (int i = 0; i < NT; i++) begin
      send(-128);
      expect_out($sformatf("sat_neg%0d", i), neg_exp[i], neg_sat[i], lat);
    end

    wcoef(0, 1); wcoef(1, 0); wcoef(2, 0); wcoef(3, 0);
    send(10);
    wcoef(1, 5);
    expect_out("mac_write_ignored", 10, 0, lat);
    wcoef(1, 5);
    send(20);            expect_out("idle_write", 70, 0, lat);
    push(30, 1, 2, 2);   expect_out("write_with_accept", 150, 0, lat);

    ordy = 1'b0;
    send(7);
    expect_out("bp", 197, 0, lat);
    iv = 1'b1;
    xv = 8'sd9;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", ir, 0);
      check("bp_valid_hold", ov, 1);
      check("bp_y_hold", yo, 197);
    end
    ordy = 1'b1;
    send(9);
    expect_out("bp_release", 104, 0, lat);

    sel = 1'b1;
    @(negedge clk);
    check("s2_in_ready", ir, 1);
    send(6);  expect_out("s2_round_pos", 2, 0, lat);
    send(-6); expect_out("s2_round_neg", -1, 0, lat);
    send(100);
    @(negedge clk);
    rst2 = 1'b1;
    seen = 0;
    repeat (2) begin @(negedge clk); if (ov != 0) seen++; end
    rst2 = 1'b0;
    repeat (NT + 3) begin @(negedge clk); if (ov != 0) seen++; end
    check("s2_abort_no_valid", seen, 0);
    check("s2_abort_in_ready", ir, 1);
    wcoef(0, 0); wcoef(1, 1); wcoef(2, 1); wcoef(3, 1);
    send(8);
    expect_out("s2_taps_zeroed", 0, 0, lat);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
